demux_pipe: RTL and testbench
=============================

DEMUX_PIPE -- requirements
Module: demux_pipe

Interface
REQ-001 SHALL have parameter DEMUX_BIT_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter SLOT_DEPTH, fixed at 2: entries per output buffer.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: an input beat is offered.
REQ-006 SHALL have port in_ready, output, 1: the selected output can accept the beat.
REQ-007 SHALL have port in_sel, input, 1: destination; 0 = out0, 1 = out1.
REQ-008 SHALL have port in_data, input, DEMUX_BIT_WIDTH: payload.
REQ-009 SHALL have port out0_valid, output, 1: out0 head entry is valid.
REQ-010 SHALL have port out0_ready, input, 1: the out0 consumer accepts.
REQ-011 SHALL have port out0_data, output, DEMUX_BIT_WIDTH: out0 head payload.
REQ-012 SHALL have ports out1_valid / out1_ready / out1_data, same as REQ-009..011 for out1.

Function
REQ-013 SHALL transfer an input beat when in_valid && in_ready at a rising edge, pushing in_data into the buffer chosen by in_sel.
REQ-014 SHALL drive in_ready = (occupancy of the buffer selected by in_sel < 2), with no combinational path from out0_ready or out1_ready.
REQ-015 SHALL ignore in_sel and in_data whenever in_valid = 0; X on those inputs SHALL NOT corrupt state.
REQ-016 SHALL have one-cycle latency: a beat pushed at edge N is visible on outX_valid/outX_data after edge N, with no combinational in-to-out path.
REQ-017 SHALL pop the head of buffer X when outX_valid && outX_ready at a rising edge.
REQ-018 SHALL keep occupancy per buffer in 0..2: push only -> +1, pop only -> -1, push and pop in the same cycle -> unchanged, with the data order preserved.
REQ-019 SHALL drive outX_valid = (occupancy_X != 0) and outX_data = head entry; once asserted, valid and data SHALL hold until popped.
REQ-020 SHALL preserve FIFO order within each output; no ordering is guaranteed between out0 and out1.
REQ-021 SHALL let the two buffers operate independently: a full out1 SHALL NOT stall beats selected to out0.
REQ-022 SHALL, at occupancy 2 with a pop that edge, still hold in_ready = 0 for that buffer; the freed slot becomes available the following cycle.
REQ-023 SHALL allow at most one push per cycle, to the buffer selected by in_sel, and a simultaneous pop on both outputs.
REQ-024 SHALL sustain one beat per cycle per output when the consumer holds ready high continuously.

Reset
REQ-025 SHALL, when rst_n = 0 at a rising edge, clear both occupancies and both read/write pointers to 0.
REQ-026 SHALL hold outputs during and after reset as follows: out0_valid = out1_valid = 0; in_ready = 1; outX_data = 0.
REQ-027 SHALL drop all buffered beats on reset mid-operation; no push or pop SHALL occur on a reset edge.

Structure
REQ-028 SHALL define DEMUX_BIT_WIDTH and SLOT_DEPTH in the shared CPU parameter header, together with the occupancy width (2 bits) and the select encoding (0/1).
REQ-029 SHALL instantiate sub-module demux_slot twice, once per output; demux_slot is a 2-entry valid/ready buffer with a write pointer, read pointer and occupancy counter.
REQ-030 SHALL contain only the select steering and in_ready muxing at top level.

Verification
REQ-031 Reset: rst_n = 0 for 2 cycles with in_valid = 1 -> both outX_valid = 0, in_ready = 1, no beats emitted after release.
REQ-032 Steering: push 0x11 (sel 0), then 0x22 (sel 1), both consumers ready -> out0 shows 0x11 and out1 shows 0x22, each one cycle after its push.
REQ-033 Full/back-pressure: out0_ready = 0, push 0xA1, 0xA2, 0xA3 to sel 0 -> in_ready drops after 2 beats. Then a sel-1 beat 0xB1 is accepted immediately. After out0_ready = 1, out0 yields 0xA1, 0xA2, 0xA3 in order.
REQ-034 Simultaneous push/pop: occupancy 1 holding 0x05, push 0x06 while popping -> occupancy stays 1, next head is 0x06.
REQ-035 Throughput: 16 sel-0 beats 0x00..0x0F, out0_ready tied high -> 16 outputs on 16 consecutive cycles, in order.
REQ-036 Reset mid-operation: both buffers full, assert rst_n = 0 one cycle -> all valids 0 next cycle, prior data never emitted.

Source files
------------

// File: rtl/demux_pipe_pkg.sv
// Shared parameters for the demux pipe: payload width, per-output buffer
// depth, occupancy counter width and the select encoding.
package demux_pipe_pkg;

    localparam int DEMUX_BIT_WIDTH_DEF = 8;
    localparam int SLOT_DEPTH_DEF      = 2;
    localparam int OCC_W               = 2;

    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } demux_sel_e;

endpackage

// File: rtl/demux_slot.sv
// Two-entry valid/ready buffer with write pointer, read pointer and
// occupancy counter. Output comes straight from registers, so a beat
// pushed at one edge is visible right after it and nothing combinational
// runs from push to output.
module demux_slot
    import demux_pipe_pkg::*;
#(
    parameter int W     = DEMUX_BIT_WIDTH_DEF,
    parameter int DEPTH = SLOT_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         full_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             pop;

    // Outputs are forced to their idle values while reset is held so the
    // consumer never sees stale state before the first reset edge.
    assign valid_o = rst_n && (occ_q != '0);
    assign data_o  = rst_n ? mem_q[rptr_q] : '0;
    assign full_o  = rst_n && (occ_q == OCC_W'(DEPTH));
    assign pop     = valid_o && ready_i;

    // Next-state for pointers and occupancy; push+pop leaves occupancy alone.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop)    rptr_d = rptr_q + 1'b1;
        case ({push_i, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset drops all buffered beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            if (push_i) mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/demux_pipe.sv
// One-in, two-out demultiplexer with a 2-entry buffer per output. The top
// only steers the beat by in_sel and muxes in_ready from the selected
// buffer's full flag, so a full out1 never stalls beats headed to out0.
module demux_pipe
    import demux_pipe_pkg::*;
#(
    parameter int DEMUX_BIT_WIDTH = DEMUX_BIT_WIDTH_DEF,
    parameter int SLOT_DEPTH      = SLOT_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sel,
    input  logic [DEMUX_BIT_WIDTH-1:0] in_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [DEMUX_BIT_WIDTH-1:0] out0_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [DEMUX_BIT_WIDTH-1:0] out1_data
);

    logic full0, full1;
    logic accept, push0, push1;

    // in_ready depends only on registered occupancy, never on outX_ready,
    // so a slot that pops this edge still reports full until next cycle.
    assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;
    // in_valid low forces both pushes low even if in_sel/in_data are X.
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_sel == SEL_OUT0);
    assign push1    = accept && (in_sel == SEL_OUT1);

    demux_slot #(.W(DEMUX_BIT_WIDTH), .DEPTH(SLOT_DEPTH)) u_slot0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push0),
        .push_data_i (in_data),
        .full_o      (full0),
        .valid_o     (out0_valid),
        .ready_i     (out0_ready),
        .data_o      (out0_data)
    );

    demux_slot #(.W(DEMUX_BIT_WIDTH), .DEPTH(SLOT_DEPTH)) u_slot1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push1),
        .push_data_i (in_data),
        .full_o      (full1),
        .valid_o     (out1_valid),
        .ready_i     (out1_ready),
        .data_o      (out1_data)
    );

endmodule

// File: tb/tb_demux_pipe.sv
// Directed bench for demux_pipe: a scoreboard queue per output is filled
// when a beat is expected to be accepted and drained by a monitor that
// samples on the falling edge whenever an output handshake is pending.
module tb_demux_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         out0_valid, out0_ready;
    logic [W-1:0] out0_data;
    logic         out1_valid, out1_ready;
    logic [W-1:0] out1_data;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp0 [$];
    logic [W-1:0] exp1 [$];

    demux_pipe #(.DEMUX_BIT_WIDTH(W), .SLOT_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer a beat and check in_ready against the expectation; an expected
    // acceptance records the payload on that output's scoreboard.
    task automatic offer(input logic sel, input logic [W-1:0] d, input logic exp_rdy, input string tag);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        #1;
        chk(tag, in_ready, exp_rdy);
        if (exp_rdy) begin
            if (sel) exp1.push_back(d);
            else     exp0.push_back(d);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sel   = 1'bx;
        in_data  = 'x;
        #1;
    endtask

    // Scoreboard drain: every output handshake must match the queue head.
    always @(negedge clk) begin
        if (out0_valid && out0_ready) begin
            checks++;
            assert (exp0.size() != 0) else begin
                failures++;
                $error("FAIL out0_extra observed=%0h expected=none", out0_data);
            end
            if (exp0.size() != 0) chk("out0_order", out0_data, exp0.pop_front());
        end
        if (out1_valid && out1_ready) begin
            checks++;
            assert (exp1.size() != 0) else begin
                failures++;
                $error("FAIL out1_extra observed=%0h expected=none", out1_data);
            end
            if (exp1.size() != 0) chk("out1_order", out1_data, exp1.pop_front());
        end
    end

    initial begin
        // Reset held two cycles with a beat offered.
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h5A;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            chk("rst_out0_valid", out0_valid, 1'b0);
            chk("rst_out1_valid", out1_valid, 1'b0);
            chk("rst_in_ready",   in_ready,   1'b1);
        end
        chk("rst_out0_data", out0_data, 8'h00);
        chk("rst_out1_data", out1_data, 8'h00);
        cyc(); rst_n = 1'b1; idle();
        cyc(); cyc();
        chk("post_rst_out0_valid", out0_valid, 1'b0);
        chk("post_rst_out1_valid", out1_valid, 1'b0);

        // Steering with both consumers ready.
        cyc(); offer(1'b0, 8'h11, 1'b1, "steer_rdy0");
        cyc(); offer(1'b1, 8'h22, 1'b1, "steer_rdy1");
        chk("steer_out0_valid", out0_valid, 1'b1);
        chk("steer_out0_data",  out0_data,  8'h11);
        cyc(); idle();
        chk("steer_out1_valid", out1_valid, 1'b1);
        chk("steer_out1_data",  out1_data,  8'h22);
        chk("steer_out0_drained", out0_valid, 1'b0);
        cyc();
        chk("steer_out1_drained", out1_valid, 1'b0);

        // Back-pressure on out0; out1 stays open.
        out0_ready = 1'b0;
        cyc(); offer(1'b0, 8'hA1, 1'b1, "bp_rdy_a1");
        cyc(); offer(1'b0, 8'hA2, 1'b1, "bp_rdy_a2");
        cyc(); offer(1'b0, 8'hA3, 1'b0, "bp_full_a3");
        cyc(); offer(1'b1, 8'hB1, 1'b1, "bp_rdy_b1");
        cyc(); idle();
        chk("bp_out1_data", out1_data, 8'hB1);
        chk("bp_out0_head", out0_data, 8'hA1);
        // Full with a pop this edge: the slot frees only next cycle.
        cyc(); out0_ready = 1'b1; offer(1'b0, 8'hA3, 1'b0, "bp_full_pop");
        cyc(); offer(1'b0, 8'hA3, 1'b1, "bp_rdy_a3");
        cyc(); idle();
        cyc(); cyc();
        chk("bp_out0_drained", out0_valid, 1'b0);

        // Simultaneous push and pop at occupancy 1.
        out0_ready = 1'b0;
        cyc(); offer(1'b0, 8'h05, 1'b1, "pp_rdy_05");
        cyc(); idle();
        chk("pp_head_05", out0_data, 8'h05);
        cyc(); out0_ready = 1'b1; offer(1'b0, 8'h06, 1'b1, "pp_rdy_06");
        cyc(); out0_ready = 1'b0; idle();
        chk("pp_valid_06", out0_valid, 1'b1);
        chk("pp_head_06",  out0_data,  8'h06);
        cyc(); out0_ready = 1'b1;
        cyc(); out0_ready = 1'b0;
        chk("pp_occ_one", out0_valid, 1'b0);

        // Throughput: one beat per cycle with out0_ready held high.
        out0_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(); offer(1'b0, W'(i), 1'b1, "tp_rdy");
            if (i > 0) begin
                chk("tp_valid", out0_valid, 1'b1);
                chk("tp_data",  out0_data,  32'(i - 1));
            end
        end
        cyc(); idle();
        chk("tp_last_data", out0_data, 8'h0F);
        cyc();
        chk("tp_drained", out0_valid, 1'b0);

        // Fill both buffers, then reset: nothing buffered may come out.
        out0_ready = 1'b0; out1_ready = 1'b0;
        cyc(); in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hC1;
        cyc(); in_data = 8'hC2;
        cyc(); in_sel = 1'b1; in_data = 8'hD1;
        cyc(); in_data = 8'hD2;
        cyc(); idle();
        in_sel = 1'b0; #1; chk("mid_full0", in_ready, 1'b0);
        in_sel = 1'b1; #1; chk("mid_full1", in_ready, 1'b0);
        idle();
        cyc(); rst_n = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        cyc(); rst_n = 1'b1; #1;
        chk("mid_out0_valid", out0_valid, 1'b0);
        chk("mid_out1_valid", out1_valid, 1'b0);
        chk("mid_out0_data",  out0_data,  8'h00);
        in_sel = 1'b0; #1; chk("mid_in_ready", in_ready, 1'b1);
        idle();
        for (int i = 0; i < 4; i++) cyc();
        chk("mid_quiet0", out0_valid, 1'b0);
        chk("mid_quiet1", out1_valid, 1'b0);

        chk("sb0_empty", exp0.size(), 0);
        chk("sb1_empty", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
